forward_scoreboard: RTL
=======================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter REG_COUNT, default 32, architectural register count; address width AW = $clog2(REG_COUNT).
REQ-002 SHALL have parameter DEPTH, default 2, number of tracked in-flight stages after ID/EX (legal 1..4).
REQ-003 SHALL have parameter LOAD_LAT, default 1, entry index at which load data becomes forwardable (legal 0..DEPTH-1).
REQ-004 SHALL have parameter STORE_LATE_FWD, default 1; when 1, store-data hazards on loads resolve by late forward instead of stall.
REQ-005 SHALL have the port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-006 SHALL have the port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have the port issue_valid, input, 1 bit, instruction in ID/EX is valid.
REQ-008 SHALL have the port issue_rd, input, AW bits, destination of ID/EX instruction.
REQ-009 SHALL have the port issue_regwrite, input, 1 bit, ID/EX instruction writes rd.
REQ-010 SHALL have the port issue_is_load, input, 1 bit, ID/EX instruction is a load.
REQ-011 SHALL have the port issue_is_store, input, 1 bit, ID/EX instruction is a store (rs2 is store data).
REQ-012 SHALL have the ports rs1_addr and rs2_addr, input, AW bits each, ID/EX source registers.
REQ-013 SHALL have the port flush, input, 1 bit, clears all tracked entries.
REQ-014 SHALL have the ports fwd_rs1 and fwd_rs2, output, SW = $clog2(DEPTH+1) bits each, forward source: 0 = register file, k = entry k-1.
REQ-015 SHALL have the port store_late, output, 1 bit, rs2 store data is forwarded in MEM from the entry selected by fwd_rs2 as it advances.
REQ-016 SHALL have the port stall, output, 1 bit, load-use hazard; hold ID/EX, insert bubble.
REQ-017 SHALL have the port stall_cnt, output, 16 bits, saturating count of stall cycles.

Function
REQ-018 SHALL hold DEPTH entries {valid, rd, regwrite, is_load}; entry 0 is the youngest, entry DEPTH-1 the oldest.
REQ-019 SHALL shift entry i into entry i+1 every cycle and discard entry DEPTH-1.
REQ-020 SHALL load entry 0 with the issue fields when issue_valid=1 and stall=0, and with valid=0 (bubble) otherwise.
REQ-021 SHALL treat entry i as matching source s when valid=1, regwrite=1, rd!=0 and rd==s.
REQ-022 SHALL set fwd_rsX = i+1 for the lowest-index matching entry (youngest wins), and 0 if there is no match or rsX==0.
REQ-023 SHALL classify a match as not ready when that entry has is_load=1 and i < LOAD_LAT.
REQ-024 SHALL assert stall combinationally when issue_valid=1 and the rs1 match is not ready or the rs2 match is not ready, except as in REQ-025.
REQ-025 SHALL, when STORE_LATE_FWD=1, issue_is_store=1 and the only not-ready match is on rs2 with i+1 >= LOAD_LAT, not stall and assert store_late=1; store_late SHALL be 0 in all other cases.
REQ-026 SHALL resolve a stall without external action, because bubbles age the load past LOAD_LAT; maximum consecutive stall cycles = LOAD_LAT.
REQ-027 SHALL give flush priority over issue: all entries valid=0 next cycle, no push; stall is still computed from current entries in the flush cycle.
REQ-028 SHALL increment stall_cnt on each cycle with stall=1 and saturate at 16'hFFFF.
REQ-029 SHALL keep all outputs except stall_cnt purely combinational from the current entries and inputs.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously clear all entries to valid=0 and clear stall_cnt to 0; with no valid entries, fwd_rs1=fwd_rs2=0 and stall=store_late=0.
REQ-031 SHALL discard all in-flight entries on reset asserted mid-operation, and SHALL resume tracking on the first rising edge after rst_n deasserts.

Verification
REQ-032 SHALL pass: with defaults, issue ALU rd=5, then next cycle rs1=5 -> fwd_rs1=1, stall=0; one cycle later (bubble issued) rs1=5 -> fwd_rs1=2.
REQ-033 SHALL pass: issue load rd=7, then rs2=7 non-store -> stall=1 for exactly 1 cycle, then fwd_rs2=2, stall=0, and stall_cnt=1.
REQ-034 SHALL pass: issue load rd=7, then store with rs2=7 -> stall=0, store_late=1, fwd_rs2=1; with STORE_LATE_FWD=0 -> stall=1.
REQ-035 SHALL pass: back-to-back writes rd=3 (ALU) then rd=3 (ALU), then rs1=3 -> fwd_rs1=1 (youngest); rd=0 writer with rs1=0 -> fwd_rs1=0.
REQ-036 SHALL pass: load rd=9 in entry 0 with flush=1 -> next cycle rs1=9 -> fwd_rs1=0, stall=0; rst_n pulse mid-stream -> stall_cnt=0 and all selects 0.
REQ-037 SHALL pass: force 70000 stall cycles -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/forward_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : forward_scoreboard
//  Description : Tracks in-flight register writers behind ID/EX and selects
//                the forwarding source for rs1/rs2. Detects load-use hazards
//                and requests a stall, or a late MEM forward when the hazard
//                is on store data and the load result arrives in time.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                issue_*              - ID/EX instruction fields
//                rs1_addr, rs2_addr   - ID/EX source registers
//                flush                - drop every tracked entry
//                fwd_rs1, fwd_rs2     - 0 = regfile, k = entry k-1
//                store_late           - store data forwarded late in MEM
//                stall                - load-use hazard, hold ID/EX
//                stall_cnt            - saturating stall-cycle counter
//  Revision    : 1.0 - initial release
// ============================================================================
module forward_scoreboard #(
  parameter int REG_COUNT      = 32,
  parameter int DEPTH          = 2,
  parameter int LOAD_LAT       = 1,
  parameter int STORE_LATE_FWD = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         issue_valid,
  input  logic [$clog2(REG_COUNT)-1:0] issue_rd,
  input  logic                         issue_regwrite,
  input  logic                         issue_is_load,
  input  logic                         issue_is_store,
  input  logic [$clog2(REG_COUNT)-1:0] rs1_addr,
  input  logic [$clog2(REG_COUNT)-1:0] rs2_addr,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rs1,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rs2,
  output logic                         store_late,
  output logic                         stall,
  output logic [15:0]                  stall_cnt
);

  localparam int AW = $clog2(REG_COUNT);
  localparam int SW = $clog2(DEPTH + 1);

  // Entry 0 is the youngest in-flight instruction, DEPTH-1 the oldest.
  logic          valid_q    [DEPTH];
  logic          valid_d    [DEPTH];
  logic [AW-1:0] rd_q       [DEPTH];
  logic [AW-1:0] rd_d       [DEPTH];
  logic          regwrite_q [DEPTH];
  logic          regwrite_d [DEPTH];
  logic          is_load_q  [DEPTH];
  logic          is_load_d  [DEPTH];
  logic [15:0]   stall_cnt_q;
  logic [15:0]   stall_cnt_d;

  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;
  logic [DEPTH-1:0] early;

  logic rs1_not_ready;
  logic rs2_not_ready;
  logic rs2_late_ok;

  // Per-entry match and "load data not yet available" flags.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam bit c_early_slot = (i < LOAD_LAT);
    logic writes;
    assign writes   = valid_q[i] && regwrite_q[i] && (rd_q[i] != '0);
    assign hit1[i]  = writes && (rd_q[i] == rs1_addr);
    assign hit2[i]  = writes && (rd_q[i] == rs2_addr);
    assign early[i] = is_load_q[i] && c_early_slot;
  end

  // Walk oldest to youngest so the youngest matching writer wins.
  always_comb begin
    fwd_rs1       = '0;
    fwd_rs2       = '0;
    rs1_not_ready = 1'b0;
    rs2_not_ready = 1'b0;
    rs2_late_ok   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit1[i]) begin
        fwd_rs1       = SW'(i + 1);
        rs1_not_ready = early[i];
      end
      if (hit2[i]) begin
        fwd_rs2       = SW'(i + 1);
        rs2_not_ready = early[i];
        // Store data is consumed one stage later, in MEM, so a load that
        // becomes forwardable by the next slot can still feed it.
        rs2_late_ok   = (i + 1 >= LOAD_LAT);
      end
    end
  end

  assign store_late = (STORE_LATE_FWD != 0) && issue_valid && issue_is_store &&
                      !rs1_not_ready && rs2_not_ready && rs2_late_ok;
  assign stall      = issue_valid && (rs1_not_ready || rs2_not_ready) && !store_late;
  assign stall_cnt  = stall_cnt_q;

  // Shift register advance; a stalled or invalid issue enters as a bubble.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i]    = valid_q[i];
      rd_d[i]       = rd_q[i];
      regwrite_d[i] = regwrite_q[i];
      is_load_d[i]  = is_load_q[i];
    end
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i]    = valid_q[i-1];
      rd_d[i]       = rd_q[i-1];
      regwrite_d[i] = regwrite_q[i-1];
      is_load_d[i]  = is_load_q[i-1];
    end
    valid_d[0]    = issue_valid && !stall;
    rd_d[0]       = issue_rd;
    regwrite_d[0] = issue_regwrite;
    is_load_d[0]  = issue_is_load;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_d[i] = 1'b0;
      end
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]    <= 1'b0;
        rd_q[i]       <= '0;
        regwrite_q[i] <= 1'b0;
        is_load_q[i]  <= 1'b0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]    <= valid_d[i];
        rd_q[i]       <= rd_d[i];
        regwrite_q[i] <= regwrite_d[i];
        is_load_q[i]  <= is_load_d[i];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire
